// File: rtl/overdrive_pipe.sv
// Overdrive effect: pre-gain with saturation, then hard or soft-knee symmetric clip, on a valid/ready stream.
// Optional noise gate enabled by defining NOISE_GATE_EN.
module overdrive_pipe #(
  parameter int DATA_W     = 16,
  parameter int MAG_W      = 4,
  parameter int GAIN_W     = 8,
  parameter int GAIN_FRAC  = 4,
  parameter int GATE_LEVEL = 64,
  parameter int GATE_HOLD  = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_cfg,
  input  logic [1:0]               cfg_mode,
  input  logic [MAG_W-1:0]         cfg_mag,
  input  logic [GAIN_W-1:0]        cfg_gain,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_clip
);

  localparam int PW = DATA_W + GAIN_W + 1;
  localparam int MAX = 2**(DATA_W-1) - 1;
  localparam logic [DATA_W-1:0] MAX_U = DATA_W'(MAX);
  localparam logic signed [PW-1:0] SAT_HI = PW'(MAX);
  localparam logic signed [PW-1:0] SAT_LO = -SAT_HI - PW'(1);
  localparam logic [1:0] MODE_HARD = 2'b01;
  localparam logic [1:0] MODE_SOFT = 2'b10;

  function automatic logic [DATA_W-1:0] thr_of(input logic [MAG_W-1:0] mag);
    logic [DATA_W+MAG_W-1:0] prod;
    prod = {{DATA_W{1'b0}}, mag} * {{MAG_W{1'b0}}, MAX_U};
    return MAX_U - prod[DATA_W+MAG_W-1:MAG_W];
  endfunction

  // One extra bit so that the most negative sample has a representable magnitude.
  function automatic logic [DATA_W:0] abs_of(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~{v[DATA_W-1], v} + 1'b1) : {1'b0, v};
  endfunction

  // Returns {sat_flag, value}.
  function automatic logic [DATA_W:0] sat_gain(input logic signed [PW-1:0] v);
    if (v > SAT_HI) return {1'b1, MAX_U};
    if (v < SAT_LO) return {1'b1, ~MAX_U};
    return {1'b0, v[DATA_W-1:0]};
  endfunction

  // Returns {clip_flag, y}; mode 00 and 11 pass the magnitude through untouched.
  function automatic logic [DATA_W:0] clip_of(input logic signed [DATA_W-1:0] p,
                                              input logic [1:0] mode,
                                              input logic [DATA_W-1:0] thr);
    logic [DATA_W:0]   a, k, t, m, thr_w;
    logic [DATA_W-1:0] y;
    a     = abs_of(p);
    thr_w = {1'b0, thr};
    k     = {2'b00, thr[DATA_W-1:1]};
    t     = k + ((a - k) >> 1);
    m     = a;
    case (mode)
      MODE_HARD: if (a > thr_w) m = thr_w;
      MODE_SOFT: if (a > k) m = (t > thr_w) ? thr_w : t;
      default:   m = a;
    endcase
    y = p[DATA_W-1] ? DATA_W'(-m) : m[DATA_W-1:0];
    return {(y != p), y};
  endfunction

  logic [1:0]        act_mode;
  logic [GAIN_W-1:0] act_gain;
  logic [DATA_W-1:0] act_thr;
  logic              adv, accept;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_mode <= MODE_HARD;
      act_gain <= GAIN_W'(1 << GAIN_FRAC);
      act_thr  <= MAX_U;
    end else if (set_cfg) begin
      act_mode <= cfg_mode;
      act_gain <= cfg_gain;
      act_thr  <= thr_of(cfg_mag);
    end
  end

  // Stage p0: pre-gain and saturate; mode/threshold snapshot taken with the sample.
  logic signed [PW-1:0]     prod_s0;
  logic [DATA_W:0]          sat_s0;
  logic                     vld_p0, sat_p0;
  logic signed [DATA_W-1:0] p_p0;
  logic [1:0]               mode_p0;
  logic [DATA_W-1:0]        thr_p0;
  logic                     gated_s0;

  assign prod_s0 = (in_data * $signed({1'b0, act_gain})) >>> GAIN_FRAC;
  assign sat_s0  = sat_gain(prod_s0);

`ifdef NOISE_GATE_EN
  localparam int CW = $clog2(GATE_HOLD + 1);
  logic [CW-1:0] gate_cnt;
  logic          quiet_s0;

  assign quiet_s0 = abs_of(in_data) < (DATA_W+1)'(GATE_LEVEL);
  assign gated_s0 = quiet_s0 && (gate_cnt == CW'(GATE_HOLD));

  always_ff @(posedge clk) begin
    if (rst) gate_cnt <= '0;
    else if (accept) begin
      if (!quiet_s0) gate_cnt <= '0;
      else if (gate_cnt != CW'(GATE_HOLD)) gate_cnt <= gate_cnt + 1'b1;
    end
  end
`else
  assign gated_s0 = 1'b0;
`endif

  logic gate_p0, gate_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else if (adv) vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p_p0    <= sat_s0[DATA_W-1:0];
      sat_p0  <= sat_s0[DATA_W];
      mode_p0 <= act_mode;
      thr_p0  <= act_thr;
      gate_p0 <= gated_s0;
    end
  end

  // Stage p1: hard/soft clip against the snapshotted threshold.
  logic [DATA_W:0]          clip_s1;
  logic                     vld_p1, clip_p1;
  logic signed [DATA_W-1:0] y_p1;

  assign clip_s1 = clip_of(p_p0, mode_p0, thr_p0);

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (adv && vld_p0) begin
      y_p1    <= clip_s1[DATA_W-1:0];
      clip_p1 <= clip_s1[DATA_W] | sat_p0;
      gate_p1 <= gate_p0;
    end
  end

  // Stage p2: output register; a closed gate forces silence and no clip indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_clip  <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= gate_p1 ? '0 : y_p1;
        out_clip <= gate_p1 ? 1'b0 : clip_p1;
      end
    end
  end

endmodule

// File: tb/tb_overdrive_pipe.sv
// Randomized and directed bench for overdrive_pipe with a behavioural scoreboard model.
// Also covers the noise gate when NOISE_GATE_EN is defined for both files.
module tb_overdrive_pipe;

  localparam int HOLD  = 4;
  localparam int LEVEL = 64;
  localparam int MAXV  = 32767;

  logic        clk = 1'b0;
  logic        rst, set_cfg, in_valid, out_ready;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_mag;
  logic [7:0]  cfg_gain;
  logic        in_ready, out_valid, out_clip;
  logic signed [15:0] in_data, out_data;

  overdrive_pipe #(.GATE_LEVEL(LEVEL), .GATE_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .set_cfg(set_cfg), .cfg_mode(cfg_mode), .cfg_mag(cfg_mag),
    .cfg_gain(cfg_gain), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_clip(out_clip)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit bp_rand = 0;

  // Model state: the configuration the bench has written, and the gate's quiet-run count.
  int m_mode = 1, m_mag = 0, m_gain = 16, gate_cnt = 0;
  int exp_y[$], exp_c[$];
  int log_y[$], log_c[$];
  int want_y[$], want_c[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input int x, output int y, output int c);
    int thr, p, a, k, t, s;
    thr = MAXV - ((m_mag * MAXV) / 16);
    p = (x * m_gain) >>> 4;
    c = 0;
    if (p > MAXV) begin p = MAXV; c = 1; end
    else if (p < -MAXV - 1) begin p = -MAXV - 1; c = 1; end
    a = (p < 0) ? -p : p;
    s = (p < 0) ? -1 : 1;
    y = p;
    if (m_mode == 1) begin
      if (a > thr) y = s * thr;
    end else if (m_mode == 2) begin
      k = thr / 2;
      if (a > k) begin
        t = k + (a - k) / 2;
        if (t > thr) t = thr;
        y = s * t;
      end
    end
    if (y != p) c = 1;
`ifdef NOISE_GATE_EN
    begin
      bit quiet;
      quiet = ((x < 0) ? -x : x) < LEVEL;
      if (quiet && gate_cnt == HOLD) begin y = 0; c = 0; end
      if (!quiet) gate_cnt = 0;
      else if (gate_cnt < HOLD) gate_cnt++;
    end
`endif
  endtask

  // Observe at the falling edge what the next rising edge will transfer.
  always @(negedge clk) begin
    int y, c;
    if (rst) begin
      exp_y.delete(); exp_c.delete();
      m_mode = 1; m_mag = 0; m_gain = 16; gate_cnt = 0;
    end else begin
      chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_y.size() == 0) chk("out_spurious", int'(out_valid), 0);
        else begin
          chk("out_data", int'(out_data), exp_y[0]);
          chk("out_clip", int'(out_clip), exp_c[0]);
          if (out_ready) begin
            log_y.push_back(int'(out_data)); log_c.push_back(int'(out_clip));
            void'(exp_y.pop_front()); void'(exp_c.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        model(int'(in_data), y, c);
        exp_y.push_back(y); exp_c.push_back(c);
      end
      if (set_cfg) begin
        m_mode = int'(cfg_mode); m_mag = int'(cfg_mag); m_gain = int'(cfg_gain);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int x);
    bit ok = 0;
    in_valid = 1'b1; in_data = 16'(x);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; step(); break; end
      step();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", int'(in_ready), 1);
  endtask

  task automatic cfg(input int mode, input int mag, input int gain);
    set_cfg = 1'b1; cfg_mode = 2'(mode); cfg_mag = 4'(mag); cfg_gain = 8'(gain);
    step();
    set_cfg = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; bp_rand = 0; out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_y.size() != 0; i++) step();
    chk("drain_left", exp_y.size(), 0);
    repeat (2) step();
  endtask

  task automatic want(input int y, input int c);
    want_y.push_back(y); want_c.push_back(c);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, log_y.size(), want_y.size());
    for (int i = 0; i < want_y.size() && i < log_y.size(); i++) begin
      chk({tag, "_y"}, log_y[i], want_y[i]);
      chk({tag, "_c"}, log_c[i], want_c[i]);
    end
    log_y.delete(); log_c.delete(); want_y.delete(); want_c.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; set_cfg = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_clip", int'(out_clip), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    log_y.delete(); log_c.delete();
  endtask

  initial begin
    int lat;
    rst = 1'b1; set_cfg = 1'b0; cfg_mode = '0; cfg_mag = '0; cfg_gain = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    do_reset();

    // Reset configuration is hard clip, mag 0, unity gain.
    in_valid = 1'b1; in_data = 16'sd1000;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin step(); lat++; end
    chk("latency", lat, 3);
    send(-1000); send(32767); send(-32768);
    drain();
    want(1000, 0); want(-1000, 0); want(32767, 0); want(-32767, 1);
    check_log("hard_mag0");

    cfg(1, 8, 16);
    send(20000); send(-20000); send(16000);
    drain();
    want(16384, 1); want(-16384, 1); want(16000, 0);
    check_log("hard_mag8");

    cfg(2, 8, 16);
    send(8000); send(12192); send(30000);
    drain();
    want(8000, 0); want(10192, 1); want(16384, 1);
    check_log("soft_mag8");

    cfg(0, 0, 32);
    send(20000); send(-300);
    drain();
    want(32767, 1); want(-600, 0);
    check_log("bypass_gain2");

    // A sample accepted in the set_cfg cycle still sees the old configuration.
    cfg(1, 0, 16);
    in_valid = 1'b1; in_data = 16'sd20000;
    set_cfg = 1'b1; cfg_mode = 2'd1; cfg_mag = 4'd8; cfg_gain = 8'd16;
    @(negedge clk);
    chk("cfg_cycle_ready", int'(in_ready), 1);
    step();
    set_cfg = 1'b0; in_valid = 1'b0;
    send(20000);
    drain();
    want(20000, 0); want(16384, 1);
    check_log("cfg_boundary");

    // Backpressure with a configuration change during the stall.
    cfg(0, 0, 16);
    send(1000); send(2000); send(3000);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'sd4000;
    step(); step();
    set_cfg = 1'b1; cfg_mode = 2'd0; cfg_mag = 4'd0; cfg_gain = 8'd32;
    step();
    set_cfg = 1'b0;
    step(); step();
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_out_valid", int'(out_valid), 1);
    chk("stall_out_data", int'(out_data), 1000);
    out_ready = 1'b1;
    send(4000); send(5000);
    drain();
    want(1000, 0); want(2000, 0); want(3000, 0); want(8000, 0); want(10000, 0);
    check_log("backpressure");

    // Reset with samples in flight discards them.
    cfg(0, 0, 16);
    send(1111); send(2222); send(3333);
    rst = 1'b1;
    step();
    chk("midrst_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    step();
    chk("midrst_idle", int'(out_valid), 0);
    log_y.delete(); log_c.delete();

`ifdef NOISE_GATE_EN
    cfg(0, 0, 16);
    repeat (5) send(10);
    send(500);
    drain();
    want(10, 0); want(10, 0); want(10, 0); want(10, 0); want(0, 0); want(500, 0);
    check_log("gate");
`endif

    // Random traffic, random configuration and random backpressure.
    bp_rand = 1;
    for (int i = 0; i < 400; i++) begin
      int r, x;
      if ($urandom_range(0, 15) == 0)
        cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      r = int'($urandom_range(0, 9));
      case (r)
        0: x = -32768;
        1: x = 32767;
        2: x = int'($urandom_range(0, 100)) - 50;
        default: x = int'($signed(16'($urandom)));
      endcase
      send(x);
      if ($urandom_range(0, 4) == 0) step();
    end
    drain();
    log_y.delete(); log_c.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
